// File: rtl/alu4_arbiter.sv
// alu4_arbiter: round-robin sequencer sharing one combinational 4-bit ALU between two requesters
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op       per-requester valid/ready operation channel (N = 0, 1)
//   alu_a/alu_b/alu_opcode        registered operands and opcode driven to the ALU
//   alu_result, alu_* flags       combinational ALU outputs captured during EXEC
//   rsp_valid/ready/id/result/flags  tagged response channel, flags = {zero, negative, carry, overflow}
//   busy                          high whenever the sequencer is not IDLE
//   done_cnt0/done_cnt1           wrapping counts of responses delivered per requester
module alu4_arbiter #(
    parameter bit FIRST_PRIO = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [1:0]       req1_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             gnt0, gnt1, hs;
    always_comb begin
        // a lone requester wins outright; on contention prio picks the winner
        gnt0         = (state_q == IDLE) & req0_valid & (~req1_valid | ~prio_q);
        gnt1         = (state_q == IDLE) & req1_valid & (~req0_valid | prio_q);
        hs           = (state_q == RESP) & rsp_valid_q & rsp_ready;
        state_d      = state_q;
        prio_d       = prio_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (gnt0 | gnt1) begin
            alu_a_d  = gnt1 ? req1_a : req0_a;
            alu_b_d  = gnt1 ? req1_b : req0_b;
            alu_op_d = gnt1 ? req1_op : req0_op;
            rsp_id_d = gnt1;
            prio_d   = ~gnt1;
            state_d  = EXEC;
        end
        if (state_q == EXEC) begin
            rsp_result_d = alu_result;
            rsp_flags_d  = {alu_zero, alu_negative, alu_carry, alu_overflow};
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
        end
        if (hs) begin
            rsp_valid_d = 1'b0;
            cnt0_d      = rsp_id_q ? cnt0_q : cnt0_q + CNT_W'(1);
            cnt1_d      = rsp_id_q ? cnt1_q + CNT_W'(1) : cnt1_q;
            state_d     = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= FIRST_PRIO;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = state_q != IDLE;
    assign done_cnt0  = cnt0_q;
    assign done_cnt1  = cnt1_q;
endmodule

// File: tb/tb_alu4_arbiter.sv
// tb_alu4_arbiter: randomized self-checking bench for alu4_arbiter against a transaction-level model
module tb_alu4_arbiter;
    localparam int CNT_W = 2;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
    logic [3:0]       req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]       req0_op = '0, req1_op = '0;
    logic             req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [3:0]       alu_a, alu_b, rsp_flags;
    logic [1:0]       alu_opcode;
    logic [7:0]       alu_result, rsp_result;
    logic             alu_zero, alu_negative, alu_carry, alu_overflow;
    logic [CNT_W-1:0] done_cnt0, done_cnt1;
    int               n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu4_arbiter #(.FIRST_PRIO(1'b0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    // Behavioural alu4: signed 4x4 multiply, 4-bit and/xor/sub zero-extended; returns {result, z, n, c, v}
    function automatic logic [11:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int   sa = $signed(a), sb = $signed(b), r;
        logic [7:0] res;
        logic c = 1'b0, v = 1'b0;
        if (op == 2'd0) begin
            r   = sa * sb;
            res = r[7:0];
        end else if (op == 2'd1) begin
            res = {4'h0, a & b};
        end else if (op == 2'd2) begin
            res = {4'h0, a ^ b};
        end else begin
            r   = sa - sb;
            res = {4'h0, a - b};
            c   = a < b;
            v   = (r > 7) || (r < -8);
        end
        return {res, res == 8'h00, (op == 2'd0) ? res[7] : res[3], c, v};
    endfunction

    assign {alu_result, alu_zero, alu_negative, alu_carry, alu_overflow} = alu_ref(alu_a, alu_b, alu_opcode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: one outstanding op, age counts cycles since acceptance
    bit         pend = 0, m_prio = 0, lid = 0, g0, g1;
    int         age = 0, cnt0 = 0, cnt1 = 0;
    logic [3:0] la = '0, lb = '0;
    logic [1:0] lop = '0;
    logic [11:0] exp_rsp;

    always @(negedge clk) begin
        if (rst) begin
            pend = 0; age = 0; cnt0 = 0; cnt1 = 0; m_prio = 0;
            la = '0; lb = '0; lop = '0; lid = 0;
        end else begin
            g0 = !pend && req0_valid && (!req1_valid || !m_prio);
            g1 = !pend && req1_valid && (!req0_valid || m_prio);
            check("req0_ready", req0_ready, g0);
            check("req1_ready", req1_ready, g1);
            check("busy", busy, pend);
            check("rsp_valid", rsp_valid, pend && age == 2);
            check("alu_ops", {alu_a, alu_b, alu_opcode}, {la, lb, lop});
            check("done_cnt0", done_cnt0, cnt0 % 4);
            check("done_cnt1", done_cnt1, cnt1 % 4);
            if (pend && age == 2) begin
                exp_rsp = alu_ref(la, lb, lop);
                check("rsp_id", rsp_id, lid);
                check("rsp_result", rsp_result, exp_rsp[11:4]);
                check("rsp_flags", rsp_flags, exp_rsp[3:0]);
            end
            if (g0 || g1) begin
                pend = 1; age = 1; lid = g1; m_prio = !g1;
                la = g1 ? req1_a : req0_a;
                lb = g1 ? req1_b : req0_b;
                lop = g1 ? req1_op : req0_op;
            end else if (pend && age == 2 && rsp_ready) begin
                pend = 0;
                if (lid) cnt1++; else cnt0++;
            end else if (pend) begin
                age = 2;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_all();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        tick(4);
    endtask

    initial begin
        tick(3);
        rst = 0;
        tick(1);
        // single multiply from requester 0: 3 * -2 = -6
        req0_valid = 1; req0_a = 4'h3; req0_b = 4'hE; req0_op = 2'b00;
        tick(1);
        req0_valid = 0;
        tick(1);
        check("mult_result", rsp_result, 8'hFA);
        check("mult_neg", rsp_flags[2], 1'b1);
        idle_all();
        // contention from reset: grants must alternate
        rst = 1; tick(1); rst = 0;
        req0_valid = 1; req0_a = 4'hC; req0_b = 4'hA; req0_op = 2'b01;
        req1_valid = 1; req1_a = 4'h5; req1_b = 4'h5; req1_op = 2'b10;
        tick(18);
        idle_all();
        // backpressure while requester 1 waits
        req0_valid = 1; req0_op = 2'b11; rsp_ready = 0;
        tick(1);
        req0_valid = 0; req1_valid = 1;
        tick(7);
        rsp_ready = 1;
        tick(4);
        idle_all();
        // subtract from requester 1: 3 - 5 -> 0xE
        req1_valid = 1; req1_a = 4'h3; req1_b = 4'h5; req1_op = 2'b11;
        tick(1);
        req1_valid = 0;
        tick(1);
        check("sub_result", rsp_result, 8'h0E);
        idle_all();
        // reset during EXEC, request held so it is granted afresh
        req0_valid = 1; req0_op = 2'b00;
        tick(1);
        rst = 1;
        tick(1);
        rst = 0;
        tick(6);
        idle_all();
        // five back-to-back requester-0 operations exercise the counter wrap
        req0_valid = 1;
        tick(15);
        idle_all();
        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            req0_valid = $urandom_range(0, 99) < 60;
            req1_valid = $urandom_range(0, 99) < 60;
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
            rsp_ready = $urandom_range(0, 99) < 70;
            rst = $urandom_range(0, 299) == 0;
            tick(1);
        end
        rst = 0;
        idle_all();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu4_arbiter.md
Name: alu4_arbiter

Overview:
Two-requester round-robin arbiter and sequencer that shares one combinational 4-bit ALU (alu4) between two clients. It accepts one operation at a time over a valid/ready handshake and drives registered operands and opcode into the ALU. It captures the 8-bit result and four flags, then returns them on a single response channel tagged with the requester ID. It sits between the board-level operand sources and the shared alu4 instance.

Parameters:
FIRST_PRIO, 0, requester favoured on the first contended arbitration after reset (0 or 1)
CNT_W, 8, width of per-requester completed-operation counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  4  requester 0 operand A
req0_b  in  4  requester 0 operand B
req0_op  in  2  requester 0 opcode (00 mult, 01 and, 10 xor, 11 sub)
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
alu_a  out  4  registered operand A to ALU
alu_b  out  4  registered operand B to ALU
alu_opcode  out  2  registered opcode to ALU
alu_result  in  8  ALU result
alu_zero, alu_negative, alu_carry, alu_overflow  in  1 each  ALU flags
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that issued the operation
rsp_result  out  8  captured result
rsp_flags  out  4  captured {zero, negative, carry, overflow}
busy  out  1  high whenever state is not IDLE
done_cnt0  out  CNT_W  responses delivered to requester 0
done_cnt1  out  CNT_W  responses delivered to requester 1

Behaviour:
- Reset (sync, active-high): state=IDLE; alu_a/alu_b/alu_opcode=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0; busy=0; done_cnt0/1=0; prio=FIRST_PRIO. Reset asserted mid-operation discards the in-flight operation; no response is emitted.
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant is combinational.
  - Only reqN_valid high: grant N.
  - Both high: grant prio.
  - Neither high: stay in IDLE.
  - reqN_ready=1 only for the granted requester, only in IDLE. Ready may depend combinationally on valid.
  - On grant: latch reqN_a/b/op into alu_a/alu_b/alu_opcode; latch N into rsp_id; prio <= ~N; go to EXEC.
- EXEC (one cycle): ALU settles on the registered operands. At the end of the cycle: rsp_result <= alu_result; rsp_flags <= {alu_zero, alu_negative, alu_carry, alu_overflow}; rsp_valid <= 1; go to RESP.
- RESP: rsp_valid, rsp_id, rsp_result and rsp_flags are held stable until rsp_ready=1.
  - On handshake (rsp_valid & rsp_ready): rsp_valid <= 0; done_cnt[rsp_id] += 1; go to IDLE.
  - No new request is accepted in the handshake cycle (no bypass).
- Latency: accept at cycle T, rsp_valid high at T+2. Minimum of 3 cycles per operation.
- alu_a, alu_b and alu_opcode hold their last values outside grant cycles.
- Counters wrap from 2^CNT_W-1 to 0 silently.
- Arbitration fairness: with both requesters continuously valid, grants strictly alternate.
- prio changes only on a grant.
- Requester inputs are ignored outside a reqN_valid & reqN_ready cycle.
- A requester that drops valid before being granted is not served and gets no response.
- Opcode and result width are passed through unchanged; this block performs no arithmetic beyond the counters.

Test Plan:
- Reset then req0 alone: a=4'b0011, b=4'b1110, op=00 -> req0_ready pulses in cycle T; rsp_valid at T+2 with rsp_id=0, rsp_result=8'hFA, negative flag=1; done_cnt0=1 after the handshake.
- Both valid from reset with FIRST_PRIO=0: req0 (C AND A, op 01) and req1 (5 XOR 5, op 10) held valid, rsp_ready=1 -> first response id=0, result 8'h08; second id=1, result 8'h00, zero=1; grants alternate 0,1,0,1 for 6 operations.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid, with req1 valid -> response fields remain constant, busy=1, req1_ready stays 0. Release -> req1 granted the cycle after the handshake.
- Sub op from req1: a=3, b=5, op=11 -> rsp_result=8'h0E; rsp_flags equal the ALU flag inputs sampled in EXEC.
- Reset mid-operation: assert rst in EXEC -> next cycle rsp_valid=0, busy=0, counters 0, prio=FIRST_PRIO; the pending request is granted afresh after rst drops.
- Counter wrap with CNT_W=2: five req0 operations -> done_cnt0 sequence 1,2,3,0,1.
